aplic_intr_scan_ctrl: RTL and testbench



---
 rtl/aplic_intr_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_aplic_intr_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/aplic_intr_scan_ctrl.sv
// Sequential top-interrupt scanner: one source group per cycle, result published once per numGroups-cycle sweep.
// Claim answered the cycle after the request (no backpressure); a claim or enable low restarts the sweep.
module aplic_intr_scan_ctrl #(
    parameter int numIntrs  = 64,
    parameter int intrPrioW = 3,
    parameter int groupSize = 8,
    localparam int numGroups = (numIntrs + groupSize - 1) / groupSize,
    localparam int idW       = $clog2(numIntrs + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [numIntrs-1:0]  intrsV,
    input  logic [intrPrioW-1:0] intrs_prio [numIntrs],
    input  logic [intrPrioW-1:0] threshold,
    input  logic                 claimReq,
    output logic                 topValid,
    output logic [idW-1:0]       topIdentity,
    output logic [intrPrioW-1:0] topPrio,
    output logic                 claimAck,
    output logic [idW-1:0]       claimIdentity,
    output logic                 clearPendingV,
    output logic [idW-1:0]       clearPendingIdx
);
    localparam int gW = (numGroups > 1) ? $clog2(numGroups) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    logic [0:0]           state;
    logic [idW-1:0]       ackId;
    logic [gW-1:0]        groupIdx;
    logic                 accV, pubV;
    logic [intrPrioW-1:0] accPrio, pubPrio;
    logic [idW-1:0]       accId, pubId;

    // Sources regrouped so the last group's out-of-range lanes read as invalid.
    logic [groupSize-1:0] laneV [numGroups];
    logic [intrPrioW-1:0] laneP [numGroups][groupSize];

    for (genvar g = 0; g < numGroups; g++) begin : g_grp
        for (genvar l = 0; l < groupSize; l++) begin : g_lane
            localparam int src = g * groupSize + l;
            if (src < numIntrs) begin : g_in
                assign laneV[g][l] = intrsV[src];
                assign laneP[g][l] = intrs_prio[src];
            end else begin : g_out
                assign laneV[g][l] = 1'b0;
                assign laneP[g][l] = '0;
            end
        end
    end

    logic                 grpV, mergeV;
    logic [intrPrioW-1:0] grpPrio, mergePrio;
    logic [idW-1:0]       grpId, mergeId;

    // Strict less-than keeps the lowest identity among equal priorities.
    always_comb begin
        grpV    = 1'b0;
        grpPrio = '0;
        grpId   = '0;
        for (int l = 0; l < groupSize; l++) begin
            if (laneV[groupIdx][l] && (!grpV || laneP[groupIdx][l] < grpPrio)) begin
                grpV    = 1'b1;
                grpPrio = laneP[groupIdx][l];
                grpId   = idW'(int'(groupIdx) * groupSize + l + 1);
            end
        end
    end

    always_comb begin
        if (grpV && (!accV || grpPrio < accPrio)) begin
            mergeV    = 1'b1;
            mergePrio = grpPrio;
            mergeId   = grpId;
        end else begin
            mergeV    = accV;
            mergePrio = accPrio;
            mergeId   = accId;
        end
    end

    assign topValid    = pubV && (threshold == '0 || pubPrio < threshold);
    assign topIdentity = topValid ? pubId : '0;
    assign topPrio     = topValid ? pubPrio : '0;

    // Index 0 is a dummy so the identity itself selects its pending bit.
    logic [numIntrs:0]    pendById;
    logic                 capture;
    logic [idW-1:0]       capId;

    assign pendById = {intrsV, 1'b0};
    assign capture  = (state == IDLE) && claimReq;
    assign capId    = (enable && topValid && pendById[topIdentity]) ? topIdentity : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ackId    <= '0;
            groupIdx <= '0;
            accV     <= 1'b0;
            accPrio  <= '0;
            accId    <= '0;
            pubV     <= 1'b0;
            pubPrio  <= '0;
            pubId    <= '0;
        end else begin
            if (state == ACK) begin
                state <= IDLE;
            end else if (claimReq) begin
                state <= ACK;
                ackId <= capId;
            end

            if (!enable || capture) begin
                groupIdx <= '0;
                accV     <= 1'b0;
                accPrio  <= '0;
                accId    <= '0;
                pubV     <= 1'b0;
                pubPrio  <= '0;
                pubId    <= '0;
            end else if (groupIdx == gW'(numGroups - 1)) begin
                pubV     <= mergeV;
                pubPrio  <= mergePrio;
                pubId    <= mergeId;
                groupIdx <= '0;
                accV     <= 1'b0;
                accPrio  <= '0;
                accId    <= '0;
            end else begin
                accV     <= mergeV;
                accPrio  <= mergePrio;
                accId    <= mergeId;
                groupIdx <= groupIdx + gW'(1);
            end
        end
    end

    assign claimAck        = (state == ACK);
    assign claimIdentity   = claimAck ? ackId : '0;
    assign clearPendingV   = claimAck && (ackId != '0);
    assign clearPendingIdx = clearPendingV ? ackId : '0;

endmodule

// File: tb/tb_aplic_intr_scan_ctrl.sv
// Bench for aplic_intr_scan_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a sweep-level reference model.
module tb_aplic_intr_scan_ctrl;
    localparam int N    = 20;
    localparam int W    = 3;
    localparam int G    = 8;
    localparam int NG   = 3;
    localparam int IDW  = 5;
    localparam int NONE = 1 << 30;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b1;
    logic [N-1:0]   intrsV = '0;
    logic [W-1:0]   intrs_prio [N];
    logic [W-1:0]   threshold = '0;
    logic           claimReq = 1'b0;
    logic           topValid;
    logic [IDW-1:0] topIdentity;
    logic [W-1:0]   topPrio;
    logic           claimAck;
    logic [IDW-1:0] claimIdentity;
    logic           clearPendingV;
    logic [IDW-1:0] clearPendingIdx;

    aplic_intr_scan_ctrl #(.numIntrs(N), .intrPrioW(W), .groupSize(G)) dut (
        .clock(clock), .reset(reset), .enable(enable), .intrsV(intrsV),
        .intrs_prio(intrs_prio), .threshold(threshold), .claimReq(claimReq),
        .topValid(topValid), .topIdentity(topIdentity), .topPrio(topPrio),
        .claimAck(claimAck), .claimIdentity(claimIdentity),
        .clearPendingV(clearPendingV), .clearPendingIdx(clearPendingIdx)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a sweep is numGroups cycles; the published winner is the
    // lexicographic minimum of (priority, identity) over everything sampled.
    int m_pos, m_best, m_pubP, m_pubId, m_ackId;
    bit m_pubV, m_ack;

    function automatic bit exp_topv();
        return m_pubV && (threshold == 0 || m_pubP < int'(threshold));
    endfunction

    initial begin
        m_pos = 0; m_best = NONE; m_pubV = 0; m_pubP = 0; m_pubId = 0; m_ack = 0; m_ackId = 0;
    end

    always @(posedge clock) begin : model
        bit tv, cap;
        int tid, k;
        tv  = exp_topv();
        tid = tv ? m_pubId : 0;
        if (reset) begin
            m_pos = 0; m_best = NONE; m_pubV = 0; m_pubP = 0; m_pubId = 0; m_ack = 0; m_ackId = 0;
        end else begin
            cap = !m_ack && claimReq;
            if (m_ack) m_ack = 0;
            else if (claimReq) begin
                m_ack = 1;
                m_ackId = (enable && tv && intrsV[tid-1]) ? tid : 0;
            end
            if (!enable || cap) begin
                m_pos = 0; m_best = NONE; m_pubV = 0; m_pubP = 0; m_pubId = 0;
            end else begin
                for (int s = m_pos * G; s < (m_pos + 1) * G && s < N; s++) begin
                    if (intrsV[s]) begin
                        k = int'(intrs_prio[s]) * 64 + s + 1;
                        if (k < m_best) m_best = k;
                    end
                end
                if (m_pos == NG - 1) begin
                    m_pubV  = (m_best != NONE);
                    m_pubP  = m_pubV ? m_best / 64 : 0;
                    m_pubId = m_pubV ? m_best % 64 : 0;
                    m_best  = NONE;
                    m_pos   = 0;
                end else m_pos++;
            end
        end
    end

    always @(negedge clock) begin : compare
        bit tv, clr;
        tv  = exp_topv();
        clr = m_ack && (m_ackId != 0);
        check("topValid", topValid, tv);
        check("topIdentity", topIdentity, tv ? m_pubId : 0);
        check("topPrio", topPrio, tv ? m_pubP : 0);
        check("claimAck", claimAck, m_ack);
        check("claimIdentity", claimIdentity, m_ack ? m_ackId : 0);
        check("clearPendingV", clearPendingV, clr);
        check("clearPendingIdx", clearPendingIdx, clr ? m_ackId : 0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_top(input string tag, input int v, input int id, input int p);
        check({tag, ".topValid"}, topValid, v);
        check({tag, ".topIdentity"}, topIdentity, id);
        check({tag, ".topPrio"}, topPrio, p);
    endtask

    task automatic expect_claim(input string tag, input int ack, input int id, input int clr);
        check({tag, ".claimAck"}, claimAck, ack);
        check({tag, ".claimIdentity"}, claimIdentity, id);
        check({tag, ".clearPendingV"}, clearPendingV, clr);
        check({tag, ".clearPendingIdx"}, clearPendingIdx, clr ? id : 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) intrs_prio[i] = W'(1 + i % 7);
        tick(); tick();

        // Single source 17 at priority 5: visible on cycle 3 after reset release.
        intrsV[16] = 1'b1; intrs_prio[16] = 3'd5; reset = 1'b0;
        expect_top("c0", 0, 0, 0); expect_claim("c0", 0, 0, 0);
        tick(); expect_top("c1", 0, 0, 0);
        tick(); expect_top("c2", 0, 0, 0);
        tick(); expect_top("c3", 1, 17, 5);

        intrsV = '0;
        intrsV[2] = 1'b1;  intrs_prio[2] = 3'd2;
        intrsV[8] = 1'b1;  intrs_prio[8] = 3'd2;
        intrsV[19] = 1'b1; intrs_prio[19] = 3'd1;
        repeat (6) tick();
        expect_top("best20", 1, 20, 1);
        intrsV[19] = 1'b0;
        repeat (6) tick();
        expect_top("tie3", 1, 3, 2);

        threshold = 3'd2; #1; expect_top("thr2", 0, 0, 0);
        threshold = 3'd3; #1; expect_top("thr3", 1, 3, 2);
        threshold = 3'd0;

        // Claim held across the ACK cycle must not produce a second ack.
        claimReq = 1'b1;
        tick(); expect_claim("claim", 1, 3, 1); check("claim.topValid", topValid, 0);
        tick(); claimReq = 1'b0; expect_claim("held", 0, 0, 0); check("held.topValid", topValid, 0);
        tick(); check("gap.topValid", topValid, 0);
        tick(); expect_top("repub", 1, 3, 2);

        intrsV[2] = 1'b0; claimReq = 1'b1;
        tick(); claimReq = 1'b0; expect_claim("stale", 1, 0, 0);

        intrsV = '0;
        repeat (6) tick();
        check("empty.topValid", topValid, 0);
        claimReq = 1'b1;
        tick(); claimReq = 1'b0; expect_claim("empty", 1, 0, 0);

        intrsV[8] = 1'b1;
        repeat (6) tick();
        expect_top("src9", 1, 9, 2);
        enable = 1'b0;
        tick(); check("dis.topValid", topValid, 0);
        claimReq = 1'b1;
        tick(); claimReq = 1'b0; expect_claim("dis", 1, 0, 0);
        enable = 1'b1;

        // Reset mid-sweep, then reset during an ACK cycle.
        intrsV = '0; intrsV[2] = 1'b1;
        repeat (6) tick();
        expect_top("pre_rst", 1, 3, 2);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; expect_top("rst", 0, 0, 0); expect_claim("rst", 0, 0, 0);
        tick(); expect_top("rst_c1", 0, 0, 0);
        tick(); expect_top("rst_c2", 0, 0, 0);
        tick(); expect_top("rst_c3", 1, 3, 2);
        claimReq = 1'b1;
        tick(); claimReq = 1'b0; expect_claim("ack_pre_rst", 1, 3, 1); reset = 1'b1;
        tick(); reset = 1'b0; expect_claim("ack_rst", 0, 0, 0); expect_top("ack_rst", 0, 0, 0);
        repeat (3) tick();
        expect_top("ack_rst_pub", 1, 3, 2);

        // Random traffic, checked every cycle by the compare process.
        repeat (3000) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) begin
                    intrsV[i] = ~intrsV[i];
                    if (intrsV[i]) intrs_prio[i] = W'($urandom_range(7, 1));
                end
            end
            if ($urandom_range(19) == 0) threshold = W'($urandom_range(7));
            claimReq = ($urandom_range(5) == 0);
            enable   = ($urandom_range(39) != 0);
            reset    = ($urandom_range(199) == 0);
        end
        reset = 1'b0; claimReq = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
